// File: rtl/fetch_buffer.sv
// fetch_buffer: sequential instruction fetch with req/gnt memory port, in-flight PC queue and decode FIFO.
// Build option: define FETCH_ALIGN_CHK_EN to fault on misaligned redirect targets instead of masking them.
module fetch_buffer #(
    parameter int XLEN = 64,
    parameter int ILEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            instr_mem_req_o,
    output logic [XLEN-1:0] instr_mem_addr_o,
    input  logic            instr_mem_gnt_i,
    input  logic            instr_mem_rvalid_i,
    input  logic [ILEN-1:0] instr_mem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            fetch_valid_o,
    input  logic            fetch_ready_i,
    output logic [ILEN-1:0] fetch_instr_o,
    output logic [XLEN-1:0] fetch_pc_o,
    output logic            fetch_fault_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [XLEN-1:0] STEP = XLEN'(ILEN / 8);
    localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   occupancy;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   pending;
    logic [CW-1:0]   drop_next;
    logic [CW:0]     in_use;
    logic [AW-1:0]   pq_wr;
    logic [AW-1:0]   pq_rd;
    logic [AW-1:0]   fq_wr;
    logic [AW-1:0]   fq_rd;
    logic [XLEN-1:0] pq_pc [DEPTH];
    logic [XLEN-1:0] fq_pc [DEPTH];
    logic [ILEN-1:0] fq_instr [DEPTH];
    logic            fault;
    logic            grant;
    logic            accept;
    logic            deq;

`ifdef FETCH_ALIGN_CHK_EN
    assign target = redirect_pc_i;
    // A misaligned redirect parks the stage until reset or an aligned redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            fault <= 1'b0;
        else if (redirect_i)
            fault <= redirect_pc_i[1:0] != 2'b00;
    end
`else
    assign target = redirect_pc_i & ~XLEN'(3);
    assign fault  = 1'b0;
`endif

    // Every buffered or in-flight instruction holds a credit, so a response always finds room.
    assign in_use           = {1'b0, occupancy} + {1'b0, outstanding};
    assign instr_mem_req_o  = reset && !redirect_i && !fault && (in_use < FULL) && (drop_cnt == '0);
    assign instr_mem_addr_o = fetch_pc;
    assign grant            = instr_mem_req_o && instr_mem_gnt_i;
    // Stray responses with nothing outstanding (e.g. after reset) are ignored.
    assign accept           = instr_mem_rvalid_i && (drop_cnt == '0) && (outstanding != '0);
    assign deq              = fetch_valid_o && fetch_ready_i;
    // On redirect every live request becomes one to drop, minus the one returning right now.
    assign pending          = drop_cnt + outstanding;
    assign drop_next        = pending - CW'(instr_mem_rvalid_i && (pending != '0));

    assign fetch_valid_o = occupancy != '0;
    assign fetch_pc_o    = fetch_valid_o ? fq_pc[fq_rd] : '0;
    assign fetch_instr_o = fetch_valid_o ? fq_instr[fq_rd] : '0;
    assign fetch_fault_o = fault;

    // Fetch PC: restart on redirect, advance by one instruction per grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            fetch_pc <= RESET_PC;
        else if (redirect_i)
            fetch_pc <= target;
        else if (grant)
            fetch_pc <= fetch_pc + STEP;
    end

    // Occupancy, outstanding and drop counters; redirect dominates all other events.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupancy   <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_i) begin
            occupancy   <= '0;
            outstanding <= '0;
            drop_cnt    <= drop_next;
        end else begin
            occupancy   <= occupancy + CW'(accept) - CW'(deq);
            outstanding <= outstanding + CW'(grant) - CW'(accept);
            drop_cnt    <= drop_cnt - CW'(instr_mem_rvalid_i && (drop_cnt != '0));
        end
    end

    // Queue pointers for the in-flight PC queue and the decode FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pq_wr <= '0;
            pq_rd <= '0;
            fq_wr <= '0;
            fq_rd <= '0;
        end else if (redirect_i) begin
            pq_wr <= '0;
            pq_rd <= '0;
            fq_wr <= '0;
            fq_rd <= '0;
        end else begin
            pq_wr <= pq_wr + AW'(grant);
            pq_rd <= pq_rd + AW'(accept);
            fq_wr <= fq_wr + AW'(accept);
            fq_rd <= fq_rd + AW'(deq);
        end
    end

    // Storage: granted PCs wait for their response, then pair with it in the FIFO.
    always_ff @(posedge clk) begin
        if (grant)
            pq_pc[pq_wr] <= fetch_pc;
        if (accept) begin
            fq_pc[fq_wr]    <= pq_pc[pq_rd];
            fq_instr[fq_wr] <= instr_mem_rdata_i;
        end
    end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Parametrised next-generation instruction fetch stage with decoupled front end.
- Generates sequential PCs and issues pipelined requests to instruction memory using a req/gnt handshake.
- Accepts in-order responses of arbitrary latency and buffers them with their PCs in a DEPTH-entry FIFO.
- Presents the FIFO head to decode under a valid/ready handshake; a redirect flushes all state, including requests already in flight.

Parameters:
- XLEN, 64, address/PC width.
- ILEN, 32, instruction width. The PC step is ILEN/8.
- DEPTH, 4, FIFO entries and maximum outstanding requests. Power of two, 2..16.
- RESET_PC, 64'h0000_0000_8000_0000, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- instr_mem_req_o  out  1  request valid.
- instr_mem_addr_o  out  XLEN  request address, equal to the fetch PC.
- instr_mem_gnt_i  in  1  request accepted this cycle when high together with req.
- instr_mem_rvalid_i  in  1  response valid. Responses arrive in order, at least 1 cycle after their grant.
- instr_mem_rdata_i  in  ILEN  response instruction.
- redirect_i  in  1  flush the stage and restart fetch.
- redirect_pc_i  in  XLEN  new fetch PC.
- fetch_valid_o  out  1  FIFO head valid.
- fetch_ready_i  in  1  decode accepts the head.
- fetch_instr_o  out  ILEN  head instruction.
- fetch_pc_o  out  XLEN  PC of the head instruction.
- fetch_fault_o  out  1  misaligned-redirect fault (FETCH_ALIGN_CHK_EN only; tied 0 otherwise).

Behaviour:
- Reset (asynchronous assert, synchronous-style release):
  - fetch_pc = RESET_PC; req_pc FIFO and instr FIFO emptied.
  - outstanding = 0; drop_cnt = 0.
  - Outputs: instr_mem_req_o = 0, fetch_valid_o = 0, fetch_fault_o = 0. fetch_instr_o and fetch_pc_o = 0 while the FIFO is empty.
  - A reset asserted mid-operation discards everything immediately; any responses that arrive afterwards must be ignored, so drop_cnt must not carry stale counts.
- Credit rule: instr_mem_req_o = !redirect_i && !fault && (occupancy + outstanding < DEPTH) && drop_cnt == 0. The address is fetch_pc.
- Grant (req && gnt): fetch_pc += ILEN/8, wrapping modulo 2^XLEN. The granted PC is pushed into an in-flight PC queue and outstanding increments.
- Response when drop_cnt == 0: pop the PC queue, push {pc, rdata} into the FIFO, outstanding decrements.
- Response when drop_cnt > 0: discard it and decrement drop_cnt.
- Dequeue (fetch_valid_o && fetch_ready_i): pop the FIFO head. Push and pop in the same cycle with the FIFO full is legal. A response is never refused, because credit guarantees space.
- Zero-bubble requirement: a full FIFO drained at 1/cycle with gnt = 1 and 1-cycle response latency sustains 1 instruction/cycle after a 2-cycle fill.
- Redirect (redirect_i = 1), effective at the next edge and dominating every other event:
  - FIFO and PC queue are emptied; fetch_valid_o = 0 the following cycle.
  - fetch_pc = redirect_pc_i.
  - drop_cnt = outstanding − (instr_mem_rvalid_i ? 1 : 0). A response arriving in the redirect cycle is discarded.
  - outstanding = 0.
  - No grant can occur in the redirect cycle, because req is low.
  - A second redirect while drop_cnt > 0 adds to drop_cnt; the count is never lost.
- Counter widths: occupancy, outstanding and drop_cnt are each clog2(DEPTH)+1 bits. drop_cnt saturation is never required, since it is bounded by DEPTH.
- fetch_pc_o and fetch_instr_o are stable while fetch_valid_o = 1 and fetch_ready_i = 0.

Optional Feature:
- Macro: FETCH_ALIGN_CHK_EN.
- Defined:
  - A redirect with redirect_pc_i[1:0] != 0 sets the fault bit. fetch_fault_o = 1 from the next cycle onward and requests stop.
  - The fault clears only on reset or on an aligned redirect.
- Undefined:
  - redirect_pc_i[1:0] is forced to 00 and fetch_fault_o is tied 0.

Test Plan:
- Reset release, gnt = 1, response latency 1, ready = 1 → first req addr 0x8000_0000; PCs 0x8000_0000, 0x8000_0004, 0x8000_0008 delivered on consecutive cycles from cycle 2.
- ready = 0, gnt = 1 → exactly 4 requests issued, req drops low, fetch_valid_o held with the PC 0x8000_0000 instruction stable; ready = 1 resumes in order with no loss.
- Response latency 3, 3 requests in flight, redirect to 0x1000 → the 3 stale responses are discarded; the next delivered pair is {0x1000, rdata}.
- Redirect in the same cycle as rvalid, 1 request outstanding → drop_cnt = 0 after the edge; the response is discarded; the next request goes to the new PC.
- fetch_pc = 0xFFFF_FFFF_FFFF_FFFC granted → the next request address is 0x0.
- FETCH_ALIGN_CHK_EN defined, redirect to 0x1002 → fetch_fault_o = 1, req = 0; a subsequent redirect to 0x2000 clears the fault and fetch resumes.
